// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART frame parser
// Purpose: parser state enum, default sync marker, UART bit time, and the
//          frame-length width helper used by the parser, its interface and bench.
// Ports:   none (package)
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_PAY  = 3'd2,
        ST_CHK  = 3'd3,
        ST_HOLD = 3'd4
    } parser_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;

    // clk cycles per UART bit at the nominal baud rate
    localparam int UART_BIT_CYC = 434;

    // Width needed to hold a length value in 0..max_len
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// rtl/uart_frame_parser_if.sv - byte input, consumer read port and status of the frame parser
// Purpose: bundles the receiver byte strobe, the consumer ack/read port and the
//          parser status pulses/levels.
// Ports:   master = receiver/consumer side (drives byte_valid, byte_data,
//          frame_ack, rd_addr); slave = parser (drives rd_data, frame_len,
//          frame_ready, frame_valid, frame_err, drop).
interface uart_frame_parser_if #(
    parameter int MAX_LEN = 16
);
    import uart_pkg::*;

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = len_width(MAX_LEN);

    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          frame_ack;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [LW-1:0] frame_len;
    logic          frame_ready;
    logic          frame_valid;
    logic          frame_err;
    logic          drop;

    modport master (
        output byte_valid, byte_data, frame_ack, rd_addr,
        input  rd_data, frame_len, frame_ready, frame_valid, frame_err, drop
    );

    modport slave (
        input  byte_valid, byte_data, frame_ack, rd_addr,
        output rd_data, frame_len, frame_ready, frame_valid, frame_err, drop
    );

endinterface

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload storage with one write port and a registered read port
// Purpose: DEPTH x 8 payload buffer; contents are not reset, only the read register is.
// Ports:   clk_i, rst_i (async, active-high), we_i/waddr_i/wdata_i write port,
//          raddr_i read address, rdata_o registered read data (1-cycle latency).
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - assembles SYNC/LEN/payload/CHK frames from a UART byte stream
// Purpose: validates frames (CHK = XOR of LEN and payload), holds a good payload
//          until acknowledged and serves it through a registered read port.
// Ports:   clk, rst (async, active-high), bus (uart_frame_parser_if.slave).
// Config:  UART_FRAME_TIMEOUT_EN - when defined, an inter-byte idle counter aborts
//          partial frames after TIMEOUT_CYC cycles; otherwise partial frames wait forever.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYC = 20 * UART_BIT_CYC
) (
    input logic              clk,
    input logic              rst,
    uart_frame_parser_if.slave bus
);

    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         LW        = len_width(MAX_LEN);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    parser_state_e state_q;
    logic [LW-1:0] len_q;
    logic [7:0]    chk_q;
    logic [AW-1:0] idx_q;
    logic [LW-1:0] frame_len_q;
    logic          frame_ready_q;
    logic          frame_valid_q;
    logic          frame_err_q;
    logic          drop_q;
    logic          timeout_hit;
    logic          in_frame;
    logic          last_pay;
    logic          buf_we;

    assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAY) || (state_q == ST_CHK);
    assign last_pay = (LW'(idx_q) == (len_q - LW'(1)));
    // The buffer only changes while collecting payload, so it is stable in HOLD.
    assign buf_we   = (state_q == ST_PAY) && bus.byte_valid;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] tmo_cnt_q;
    logic [CW-1:0] tmo_cnt_d;

    assign timeout_hit = in_frame && !bus.byte_valid && (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));

    // Counts idle cycles only inside a partial frame; any byte or leaving the
    // frame states restarts it.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (bus.byte_valid || !in_frame || timeout_hit) begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            chk_q         <= '0;
            idx_q         <= '0;
            frame_len_q   <= '0;
            frame_ready_q <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            drop_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.byte_valid && (bus.byte_data == SYNC_BYTE)) begin
                        state_q <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (bus.byte_valid) begin
                        if ((bus.byte_data == 8'd0) || (bus.byte_data > MAX_LEN_B)) begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            len_q   <= LW'(bus.byte_data);
                            chk_q   <= bus.byte_data;
                            idx_q   <= '0;
                            state_q <= ST_PAY;
                        end
                    end else if (timeout_hit) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_PAY: begin
                    if (bus.byte_valid) begin
                        chk_q <= chk_q ^ bus.byte_data;
                        idx_q <= idx_q + 1'b1;
                        if (last_pay) begin
                            state_q <= ST_CHK;
                        end
                    end else if (timeout_hit) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_CHK: begin
                    if (bus.byte_valid) begin
                        if (bus.byte_data == chk_q) begin
                            frame_valid_q <= 1'b1;
                            frame_len_q   <= len_q;
                            frame_ready_q <= 1'b1;
                            state_q       <= ST_HOLD;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end else if (timeout_hit) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    // A byte arriving with the ack is still dropped, never parsed.
                    if (bus.byte_valid) begin
                        drop_q <= 1'b1;
                    end
                    if (bus.frame_ack) begin
                        frame_ready_q <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (buf_we),
        .waddr_i (idx_q),
        .wdata_i (bus.byte_data),
        .raddr_i (bus.rd_addr),
        .rdata_o (bus.rd_data)
    );

    assign bus.frame_len   = frame_len_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.drop        = drop_q;

endmodule
